alu_accumulator: RTL and testbench

Datapath execute stage directly downstream of the B-bus selector. It consumes the 8-bit B_bus as its second operand and combines it with an internal accumulator. Single-cycle logic/arithmetic ops complete in one clock. MUL is an iterative 8-step shift-add. The control unit sees a start/busy/done handshake plus Z/C/N flags.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/shift_add_multiplier.sv | 41 ++++
 rtl/alu_accumulator.sv | 136 +++++++++++++
 tb/tb_alu_accumulator.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the accumulator execute stage and the control unit that drives op.
package alu_pkg;

  localparam int ACC_WIDTH = 8;
  localparam int MUL_STEPS = 8;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_LDA = 4'd1,
    OP_ADD = 4'd2,
    OP_SUB = 4'd3,
    OP_AND = 4'd4,
    OP_OR  = 4'd5,
    OP_XOR = 4'd6,
    OP_SHL = 4'd7,
    OP_SHR = 4'd8,
    OP_MUL = 4'd9,
    OP_CLR = 4'd10
  } alu_op_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MULT = 1'b1
  } alu_state_t;

endpackage

// File: rtl/shift_add_multiplier.sv
// Iterative unsigned shift-add multiplier: load latches both operands, each step retires one
// multiplier bit.
module shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product
);

  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [2*WIDTH-1:0] addend;

  // product already includes the current step's partial term, so the caller can capture the
  // final value on the same edge as the last step.
  assign addend  = mplier_q[0] ? mcand_q : '0;
  assign product = prod_q + addend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
    end else if (load) begin
      mcand_q  <= {{WIDTH{1'b0}}, a};
      mplier_q <= b;
      prod_q   <= '0;
    end else if (step) begin
      prod_q   <= product;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
    end
  end

endmodule

// File: rtl/alu_accumulator.sv
// Execute stage: accumulator with single-cycle ALU ops and an 8-step iterative MUL.
// Handshake: start is accepted on a rising edge when busy=0; done pulses for one cycle after completion.
module alu_accumulator
  import alu_pkg::*;
#(
  parameter int WIDTH = ACC_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] B_bus,
  input  logic [3:0]       op,
  input  logic             start,
  output logic [WIDTH-1:0] acc_out,
  output logic             busy,
  output logic             done,
  output logic             Z,
  output logic             C,
  output logic             N,
  output logic             dbg_state
);

  alu_state_t       state_q, state_d;
  logic [2:0]       cnt_q;
  logic [WIDTH-1:0] acc_q;
  logic             z_q, c_q, n_q, done_q;

  alu_op_t          op_e;
  logic             accept, mul_op, last_step;
  logic             alu_wr, alu_c;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH:0]   wide;
  logic [2*WIDTH-1:0] product;

  assign op_e      = alu_op_t'(op);
  assign accept    = start && (state_q == S_IDLE);
  assign mul_op    = (op_e == OP_MUL);
  assign last_step = (state_q == S_MULT) && (cnt_q == 3'(MUL_STEPS - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept && mul_op) state_d = S_MULT;
      S_MULT: if (last_step) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    alu_wr  = 1'b1;
    alu_c   = 1'b0;
    alu_res = '0;
    wide    = '0;
    case (op_e)
      OP_LDA: alu_res = B_bus;
      OP_ADD: begin
        wide    = {1'b0, acc_q} + {1'b0, B_bus};
        alu_res = wide[WIDTH-1:0];
        alu_c   = wide[WIDTH];
      end
      OP_SUB: begin
        // Unsigned subtract wraps into the extra bit exactly when acc < B.
        wide    = {1'b0, acc_q} - {1'b0, B_bus};
        alu_res = wide[WIDTH-1:0];
        alu_c   = wide[WIDTH];
      end
      OP_AND: alu_res = acc_q & B_bus;
      OP_OR:  alu_res = acc_q | B_bus;
      OP_XOR: alu_res = acc_q ^ B_bus;
      OP_SHL: begin
        alu_res = {acc_q[WIDTH-2:0], 1'b0};
        alu_c   = acc_q[WIDTH-1];
      end
      OP_SHR: begin
        alu_res = {1'b0, acc_q[WIDTH-1:1]};
        alu_c   = acc_q[0];
      end
      OP_CLR: alu_res = '0;
      default: alu_wr = 1'b0;
    endcase
  end

  shift_add_multiplier #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept && mul_op),
    .step    (state_q == S_MULT),
    .a       (acc_q),
    .b       (B_bus),
    .product (product)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      n_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      if (accept && !mul_op) begin
        done_q <= 1'b1;
        if (alu_wr) begin
          acc_q <= alu_res;
          z_q   <= (alu_res == '0);
          c_q   <= alu_c;
          n_q   <= alu_res[WIDTH-1];
        end
      end
      if (accept && mul_op) begin
        cnt_q <= '0;
      end else if (state_q == S_MULT) begin
        cnt_q <= cnt_q + 3'd1;
        if (last_step) begin
          acc_q  <= product[WIDTH-1:0];
          z_q    <= (product[WIDTH-1:0] == '0);
          c_q    <= |product[2*WIDTH-1:WIDTH];
          n_q    <= product[WIDTH-1];
          done_q <= 1'b1;
        end
      end
    end
  end

  assign acc_out   = acc_q;
  assign busy      = (state_q == S_MULT);
  assign done      = done_q;
  assign Z         = z_q;
  assign C         = c_q;
  assign N         = n_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_accumulator.sv
// Self-checking bench for alu_accumulator against an arithmetic reference model.
module tb_alu_accumulator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] B_bus;
  logic [3:0] op;
  logic       start;
  logic [7:0] acc_out;
  logic       busy, done, Z, C, N, dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] acc_m;
  logic       z_m, c_m, n_m;

  alu_accumulator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .B_bus     (B_bus),
    .op        (op),
    .start     (start),
    .acc_out   (acc_out),
    .busy      (busy),
    .done      (done),
    .Z         (Z),
    .C         (C),
    .N         (N),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Reference: result and flags computed with plain integer arithmetic.
  task automatic model_apply(input logic [3:0] o, input logic [7:0] b);
    int a, bi, r;
    a  = int'(acc_m);
    bi = int'(b);
    case (o)
      4'd1:  begin r = bi;      c_m = 1'b0; end
      4'd2:  begin r = a + bi;  c_m = (r > 255); end
      4'd3:  begin r = a - bi;  c_m = (a < bi); end
      4'd4:  begin r = a & bi;  c_m = 1'b0; end
      4'd5:  begin r = a | bi;  c_m = 1'b0; end
      4'd6:  begin r = a ^ bi;  c_m = 1'b0; end
      4'd7:  begin r = a * 2;   c_m = (a >= 128); end
      4'd8:  begin r = a / 2;   c_m = (a % 2 == 1); end
      4'd9:  begin r = a * bi;  c_m = (r > 255); end
      4'd10: begin r = 0;       c_m = 1'b0; end
      default: return;
    endcase
    acc_m = r[7:0];
    z_m   = (acc_m == 8'd0);
    n_m   = (acc_m >= 8'd128);
  endtask

  task automatic model_reset();
    acc_m = 8'd0;
    z_m   = 1'b0;
    c_m   = 1'b0;
    n_m   = 1'b0;
  endtask

  function automatic logic [12:0] obs();
    return {acc_out, Z, C, N, busy, done};
  endfunction

  function automatic logic [12:0] expv(input logic bz, input logic dn);
    return {acc_m, z_m, c_m, n_m, bz, dn};
  endfunction

  // Called at a negedge: presents a request for one edge, returns at the following negedge.
  task automatic drive(input logic [3:0] o, input logic [7:0] b);
    start = 1'b1;
    op    = o;
    B_bus = b;
    @(negedge clk);
    start = 1'b0;
    op    = 4'($urandom_range(0, 15));
    B_bus = 8'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    op    = 4'd0;
    B_bus = 8'd0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if (obs() !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_values: got %h want %h", obs(), 13'd0);
    end
    for (int i = 0; i < 5; i++) begin
      B_bus = 8'($urandom);
      op    = 4'($urandom_range(0, 15));
      @(negedge clk);
      n_checks++;
      if (obs() !== expv(1'b0, 1'b0)) begin
        n_fail++;
        $display("FAIL reset_idle_%0d: got %h want %h", i, obs(), expv(1'b0, 1'b0));
      end
    end
  endtask

  task automatic test_lda_add();
    drive(4'd1, 8'h3C);
    model_apply(4'd1, 8'h3C);
    n_checks++;
    if (obs() !== expv(1'b0, 1'b1)) begin
      n_fail++;
      $display("FAIL lda_3c: got %h want %h", obs(), expv(1'b0, 1'b1));
    end
    drive(4'd2, 8'hD0);
    model_apply(4'd2, 8'hD0);
    n_checks++;
    if ({acc_out, Z, C, N, done} !== {8'h0C, 1'b0, 1'b1, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL add_d0: got acc=%h Z=%b C=%b N=%b done=%b want acc=0c Z=0 C=1 N=0 done=1",
               acc_out, Z, C, N, done);
    end
    @(negedge clk);
    n_checks++;
    if (obs() !== expv(1'b0, 1'b0)) begin
      n_fail++;
      $display("FAIL done_one_cycle: got %h want %h", obs(), expv(1'b0, 1'b0));
    end
  endtask

  task automatic test_sub();
    drive(4'd1, 8'h05);
    model_apply(4'd1, 8'h05);
    drive(4'd3, 8'h05);
    model_apply(4'd3, 8'h05);
    n_checks++;
    if ({acc_out, Z, C, N, done} !== {8'h00, 1'b1, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL sub_zero: got acc=%h Z=%b C=%b N=%b done=%b want acc=00 Z=1 C=0 N=0 done=1",
               acc_out, Z, C, N, done);
    end
    drive(4'd3, 8'h01);
    model_apply(4'd3, 8'h01);
    n_checks++;
    if ({acc_out, Z, C, N} !== {8'hFF, 1'b0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL sub_borrow: got acc=%h Z=%b C=%b N=%b want acc=ff Z=0 C=1 N=1",
               acc_out, Z, C, N);
    end
    @(negedge clk);
  endtask

  // Runs a MUL from a negedge; an ADD request is presented at busy cycle inject (0 = none).
  task automatic run_mul(input logic [7:0] b, input int inject, input string tag);
    drive(4'd9, b);
    n_checks++;
    if (obs() !== expv(1'b1, 1'b0)) begin
      n_fail++;
      $display("FAIL %s_busy_start: got %h want %h", tag, obs(), expv(1'b1, 1'b0));
    end
    for (int k = 1; k <= 7; k++) begin
      if (k == inject) begin
        start = 1'b1;
        op    = 4'd2;
        B_bus = 8'($urandom);
      end
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if (obs() !== expv(1'b1, 1'b0)) begin
        n_fail++;
        $display("FAIL %s_busy_%0d: got %h want %h", tag, k, obs(), expv(1'b1, 1'b0));
      end
    end
    @(negedge clk);
    model_apply(4'd9, b);
    n_checks++;
    if (obs() !== expv(1'b0, 1'b1)) begin
      n_fail++;
      $display("FAIL %s_result: got %h want %h", tag, obs(), expv(1'b0, 1'b1));
    end
  endtask

  task automatic test_mul();
    drive(4'd1, 8'h0F);
    model_apply(4'd1, 8'h0F);
    run_mul(8'h11, 3, "mul_0f_11");
    n_checks++;
    if ({acc_out, Z, C, N} !== {8'hFF, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL mul_ff_const: got acc=%h Z=%b C=%b N=%b want acc=ff Z=0 C=0 N=1",
               acc_out, Z, C, N);
    end
    // Issued on the cycle where done is high: must be accepted.
    drive(4'd1, 8'h20);
    model_apply(4'd1, 8'h20);
    n_checks++;
    if (obs() !== expv(1'b0, 1'b1)) begin
      n_fail++;
      $display("FAIL lda_after_done: got %h want %h", obs(), expv(1'b0, 1'b1));
    end
    run_mul(8'h10, 0, "mul_20_10");
    n_checks++;
    if ({acc_out, Z, C, N} !== {8'h00, 1'b1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL mul_overflow_const: got acc=%h Z=%b C=%b N=%b want acc=00 Z=1 C=1 N=0",
               acc_out, Z, C, N);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_mul();
    drive(4'd1, 8'h37);
    model_apply(4'd1, 8'h37);
    drive(4'd9, 8'h5B);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (obs() !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_mid_mul: got %h want %h", obs(), 13'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs() !== 13'd0) begin
        n_fail++;
        $display("FAIL no_done_after_abort_%0d: got %h want %h", i, obs(), 13'd0);
      end
    end
    drive(4'd1, 8'h42);
    model_apply(4'd1, 8'h42);
    n_checks++;
    if ({acc_out, done} !== {8'h42, 1'b1}) begin
      n_fail++;
      $display("FAIL lda_after_abort: got acc=%h done=%b want acc=42 done=1", acc_out, done);
    end
    @(negedge clk);
  endtask

  task automatic test_shift_nop();
    drive(4'd1, 8'h81);
    model_apply(4'd1, 8'h81);
    drive(4'd7, 8'hFF);
    model_apply(4'd7, 8'hFF);
    n_checks++;
    if ({acc_out, C, Z, N} !== {8'h02, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL shl: got acc=%h C=%b Z=%b N=%b want acc=02 C=1 Z=0 N=0", acc_out, C, Z, N);
    end
    drive(4'd1, 8'h01);
    model_apply(4'd1, 8'h01);
    drive(4'd8, 8'hFF);
    model_apply(4'd8, 8'hFF);
    n_checks++;
    if ({acc_out, C, Z, N} !== {8'h00, 1'b1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL shr: got acc=%h C=%b Z=%b N=%b want acc=00 C=1 Z=1 N=0", acc_out, C, Z, N);
    end
    drive(4'hE, 8'hA5);
    n_checks++;
    if ({acc_out, Z, C, N, busy, done} !== {8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reserved_nop: got %h want acc=00 Z=1 C=1 N=0 busy=0 done=1", obs());
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [3:0] o;
    logic [7:0] b;
    for (int i = 0; i < 16; i++) begin
      do o = 4'($urandom_range(0, 15)); while (o == 4'd9);
      b     = 8'($urandom);
      start = 1'b1;
      op    = o;
      B_bus = b;
      @(negedge clk);
      model_apply(o, b);
      n_checks++;
      if (obs() !== expv(1'b0, 1'b1)) begin
        n_fail++;
        $display("FAIL b2b_%0d op=%0d b=%h: got %h want %h", i, o, b, obs(), expv(1'b0, 1'b1));
      end
    end
    start = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs() !== expv(1'b0, 1'b0)) begin
      n_fail++;
      $display("FAIL b2b_end: got %h want %h", obs(), expv(1'b0, 1'b0));
    end
  endtask

  task automatic test_random();
    logic [3:0] o;
    logic [7:0] b;
    for (int i = 0; i < 30; i++) begin
      o = 4'($urandom_range(0, 15));
      b = 8'($urandom);
      if (o == 4'd9) begin
        run_mul(b, int'($urandom_range(0, 7)), "rand_mul");
      end else begin
        drive(o, b);
        model_apply(o, b);
        n_checks++;
        if (obs() !== expv(1'b0, 1'b1)) begin
          n_fail++;
          $display("FAIL rand_%0d op=%0d b=%h: got %h want %h", i, o, b, obs(), expv(1'b0, 1'b1));
        end
      end
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_lda_add();
    test_sub();
    test_mul();
    test_reset_mid_mul();
    test_shift_nop();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
